pipe_hazard_ctrl: RTL

Hazard and stall controller for the five-stage pipeline. It is the block that drives the enable and clear inputs of the stage registers. It compares the source registers of the instruction in D against the pending destinations in E and M, and tracks the multiply/divide unit's busy period with an internal counter. From these it produces the PC enable, the F/D enable and the D/E bubble clear, plus a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/md_busy_ctr.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-use / result-ready encodings, MD latencies
// and the source-operand hazard compare used by the stall controller.
package pipe_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam tuse_t TUSE_D    = 2'd0;
  localparam tuse_t TUSE_E    = 2'd1;
  localparam tuse_t TUSE_M    = 2'd2;
  localparam tuse_t TUSE_NONE = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // A source stalls if a younger producer cannot forward before the operand is needed.
  function automatic logic src_hazard(input logic [4:0] rs, input tuse_t tuse,
                                      input logic [4:0] e_wa, input tnew_t e_tnew,
                                      input logic [4:0] m_wa, input tnew_t m_tnew);
    return (tuse != TUSE_NONE) && (rs != 5'd0) &&
           (((rs == e_wa) && (e_tnew > tuse)) || ((rs == m_wa) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy tracker: loads the operation latency on a start from idle
// and counts down to zero; starts while busy are ignored.
module md_busy_ctr
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       div,
  output logic       busy,
  output logic [3:0] count
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  md_state_e  state_q;
  logic [3:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      count_q <= 4'd0;
    end else begin
      case (state_q)
        MD_IDLE: if (start) begin
          count_q <= div ? DIV_LD : MULT_LD;
          // A zero latency never enters BUSY, keeping busy == (count != 0).
          state_q <= ((div ? DIV_LD : MULT_LD) != 4'd0) ? MD_BUSY : MD_IDLE;
        end
        MD_BUSY: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: combinational stage enables and
// bubble clear from data and MD hazards, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [4:0]       e_wa,
  input  logic [4:0]       m_wa,
  input  logic [1:0]       e_tnew,
  input  logic [1:0]       m_tnew,
  input  logic             d_is_md,
  input  logic             e_md_start,
  input  logic             e_md_div,
  output logic             en_pc,
  output logic             en_fd,
  output logic             clr_de,
  output logic             stall,
  output logic             md_busy,
  output logic [3:0]       md_count,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             haz_rs, haz_rt, haz_md;
  logic [CNT_W-1:0] stall_cnt_q;

  md_busy_ctr #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
    .clk   (clk),
    .reset (reset),
    .start (e_md_start),
    .div   (e_md_div),
    .busy  (md_busy),
    .count (md_count)
  );

  assign haz_rs = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
  assign haz_rt = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
  // The start cycle itself stalls: the count is not loaded until the next edge.
  assign haz_md = d_is_md & (md_busy | e_md_start);

  assign stall  = haz_rs | haz_rt | haz_md;
  assign en_pc  = ~stall;
  assign en_fd  = ~stall;
  assign clr_de = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
